// File: rtl/cfg_loop_ctrl_pkg.sv
// cfg_loop_ctrl_pkg: shared FSM encoding and default widths for the loop controller
package cfg_loop_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_ROW_W = 4;
  localparam int DEF_BLK_W = 6;
  localparam int DEF_FRM_W = 4;
  localparam int DEF_PAT_W = 4;
  localparam int DEF_LAY_W = 4;
  localparam int STALL_W = 32;
endpackage

// File: rtl/cfg_loop_cnt.sv
// cfg_loop_cnt: one odometer digit; counts up on inc and wraps to 0 after reaching bound
module cfg_loop_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] bound,
  output logic [W-1:0] idx,
  output logic         wrap
);
  assign wrap = idx == bound;
  // index register: cleared on reset or run load, advanced on inc
  always_ff @(posedge clk) begin
    if (!rst_n || clr) idx <= '0;
    else if (inc) idx <= wrap ? '0 : idx + W'(1);
  end
endmodule

// File: rtl/cfg_loop_ctrl.sv
// cfg_loop_ctrl: snapshots CFG_* bounds and walks layer>patch>frame>block>row, one handshaked step per row; CFG_LOOP_STALL_CNT_EN enables the backpressure counter
module cfg_loop_ctrl
  import cfg_loop_ctrl_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int BLK_W = DEF_BLK_W,
  parameter int FRM_W = DEF_FRM_W,
  parameter int PAT_W = DEF_PAT_W,
  parameter int LAY_W = DEF_LAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ROW_W-1:0]   CFG_LenRow,
  input  logic [BLK_W-1:0]   CFG_DepBlk,
  input  logic [BLK_W-1:0]   CFG_NumBlk,
  input  logic [FRM_W-1:0]   CFG_NumFrm,
  input  logic [PAT_W-1:0]   CFG_NumPat,
  input  logic [LAY_W-1:0]   CFG_NumLay,
  output logic               step_vld,
  input  logic               step_rdy,
  output logic [ROW_W-1:0]   idx_row,
  output logic [BLK_W-1:0]   idx_blk,
  output logic [FRM_W-1:0]   idx_frm,
  output logic [PAT_W-1:0]   idx_pat,
  output logic [LAY_W-1:0]   idx_lay,
  output logic [BLK_W-1:0]   dep_blk,
  output logic               last_row,
  output logic               last_blk,
  output logic               last_frm,
  output logic               last_pat,
  output logic               last_lay,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);
  state_t state, state_nxt;
  logic [ROW_W-1:0] len_row;
  logic [BLK_W-1:0] num_blk;
  logic [FRM_W-1:0] num_frm;
  logic [PAT_W-1:0] num_pat;
  logic [LAY_W-1:0] num_lay;
  logic w_row, w_blk, w_frm, w_pat, w_lay;
  logic at_row, at_blk, at_frm, at_pat, at_lay;
  logic hs, adv, load;
  assign load = state == LOAD;
  assign hs = step_vld && step_rdy;
  assign at_row = w_row;
  assign at_blk = at_row && w_blk;
  assign at_frm = at_blk && w_frm;
  assign at_pat = at_frm && w_pat;
  assign at_lay = at_pat && w_lay;
  assign adv = hs && !at_lay;
  assign last_row = step_vld && at_row;
  assign last_blk = step_vld && at_blk;
  assign last_frm = step_vld && at_frm;
  assign last_pat = step_vld && at_pat;
  assign last_lay = step_vld && at_lay;
  cfg_loop_cnt #(.W(ROW_W)) u_row (.clk(clk), .rst_n(rst_n), .clr(load), .inc(adv), .bound(len_row), .idx(idx_row), .wrap(w_row));
  cfg_loop_cnt #(.W(BLK_W)) u_blk (.clk(clk), .rst_n(rst_n), .clr(load), .inc(adv && at_row), .bound(num_blk), .idx(idx_blk), .wrap(w_blk));
  cfg_loop_cnt #(.W(FRM_W)) u_frm (.clk(clk), .rst_n(rst_n), .clr(load), .inc(adv && at_blk), .bound(num_frm), .idx(idx_frm), .wrap(w_frm));
  cfg_loop_cnt #(.W(PAT_W)) u_pat (.clk(clk), .rst_n(rst_n), .clr(load), .inc(adv && at_frm), .bound(num_pat), .idx(idx_pat), .wrap(w_pat));
  cfg_loop_cnt #(.W(LAY_W)) u_lay (.clk(clk), .rst_n(rst_n), .clr(load), .inc(adv && at_pat), .bound(num_lay), .idx(idx_lay), .wrap(w_lay));
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: start only honoured in IDLE, final handshake ends the run
  always_comb begin
    state_nxt = state == IDLE ? (start ? LOAD : IDLE) :
                state == LOAD ? RUN :
                state == RUN  ? (hs && at_lay ? DONE : RUN) : IDLE;
  end
  // state-decoded outputs
  always_comb begin
    step_vld = state == RUN;
    busy = state != IDLE;
    done = state == DONE;
  end
  // shadow bounds snapshot taken once per run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_row <= '0;
      dep_blk <= '0;
      num_blk <= '0;
      num_frm <= '0;
      num_pat <= '0;
      num_lay <= '0;
    end else if (load) begin
      len_row <= CFG_LenRow;
      dep_blk <= CFG_DepBlk;
      num_blk <= CFG_NumBlk;
      num_frm <= CFG_NumFrm;
      num_pat <= CFG_NumPat;
      num_lay <= CFG_NumLay;
    end
  end
`ifdef CFG_LOOP_STALL_CNT_EN
  // saturating count of cycles where a step is offered but not taken
  always_ff @(posedge clk) begin
    if (!rst_n || load) stall_cnt <= '0;
    else if (step_vld && !step_rdy && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
